alu_sweep_checker: RTL and testbench
====================================

ALU_SWEEP_CHECKER -- requirements
Module: alu_sweep_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, range 1..15: cycles each vector is held on the ALU before its result is sampled.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request a full sweep; sampled only in IDLE.
REQ-005 SHALL have port op_sel  input  2  ALU operation to sweep; latched when start is accepted.
REQ-006 SHALL have port alu_a  output  2  operand A driven to the ALU under test.
REQ-007 SHALL have port alu_b  output  2  operand B driven to the ALU under test.
REQ-008 SHALL have port alu_sel  output  2  operation select driven to the ALU under test.
REQ-009 SHALL have port alu_y  input  4  result returned by the ALU under test.
REQ-010 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-012 SHALL have port pass  output  1  high when the last completed sweep had zero mismatches.
REQ-013 SHALL have port err_count  output  5  mismatch count of the last or current sweep, 0..16.
REQ-014 SHALL have port first_fail_idx  output  4  vector index of the first mismatch.
REQ-015 SHALL have port first_fail_y  output  4  alu_y value captured at the first mismatch.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, CHECK, DONE; all outputs registered.
REQ-017 SHALL, in IDLE with start=1, latch op_sel into alu_sel, load vector 0, clear err_count/pass/first_fail_*, set busy, go to WAIT.
REQ-018 SHALL sweep vector index i = 0..15 in ascending order with alu_a = i[3:2], alu_b = i[1:0].
REQ-019 SHALL stay in WAIT for exactly SETTLE_CYCLES cycles, then go to CHECK for one cycle.
REQ-020 SHALL, in CHECK, compare alu_y with the expected value and increment err_count on mismatch.
REQ-021 SHALL compute expected values mod 16: sel 00 = A+B; sel 01 = A-B as 4-bit two's complement; sel 10 = A*B; sel 11 = {2'b00, A&B}.
REQ-022 SHALL capture first_fail_idx = i and first_fail_y = alu_y only on the first mismatch of a sweep.
REQ-023 SHALL, in CHECK with i<15, load vector i+1 and return to WAIT; with i=15, go to DONE.
REQ-024 SHALL assert done on the 16*(SETTLE_CYCLES+1)-th rising edge after the edge that accepted start (32 for default).
REQ-025 SHALL, in DONE, pulse done for one cycle, set pass = (err_count==0), clear busy, return to IDLE.
REQ-026 SHALL ignore start while busy; start held high re-triggers a new sweep the cycle after DONE.
REQ-027 SHALL hold alu_a/alu_b/alu_sel, pass, err_count and first_fail_* stable in IDLE until the next accepted start.
REQ-028 SHALL count a mismatch at the final vector (i=15) before pass is evaluated.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-sweep, immediately force state IDLE and all outputs to 0 (alu_a, alu_b, alu_sel, busy, done, pass, err_count, first_fail_idx, first_fail_y).
REQ-030 SHALL remain in IDLE after rst_n deasserts until start is sampled high.

Verification
REQ-031 SHALL cover: correct ALU model, op_sel=00, SETTLE_CYCLES=1, start pulse -> done at edge 32, pass=1, err_count=0.
REQ-032 SHALL cover: ALU model with alu_y[0] stuck at 0, op_sel=00 -> err_count=8, first_fail_idx=1, first_fail_y=0, pass=0.
REQ-033 SHALL cover: correct model, op_sel=01 -> vector 1 (A=0,B=1) sampled 4'b1111, pass=1; op_sel=10 -> vector 15 sampled 4'd9, pass=1.
REQ-034 SHALL cover: start pulsed again at edge 10 of a running sweep -> ignored, done still at edge 32, single done pulse.
REQ-035 SHALL cover: rst_n driven low between edges 9 and 10 -> busy, alu_a, alu_b, err_count read 0 before edge 10; no activity after release until start.
REQ-036 SHALL cover: SETTLE_CYCLES=3, ALU model with 2-cycle output delay -> pass=1, done at edge 64.

Source files
------------

// File: rtl/alu_sweep_checker_if.sv
// Bus between the sweep checker and its environment: control, ALU drive and result/status.
// The checker takes the slave view; the environment driving start/op_sel and alu_y takes master.
interface alu_sweep_checker_if;
  logic       start;
  logic [1:0] op_sel;
  logic [1:0] alu_a;
  logic [1:0] alu_b;
  logic [1:0] alu_sel;
  logic [3:0] alu_y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic [3:0] first_fail_idx;
  logic [3:0] first_fail_y;

  modport master (
    output start, op_sel, alu_y,
    input  alu_a, alu_b, alu_sel, busy, done, pass, err_count, first_fail_idx, first_fail_y
  );

  modport slave (
    input  start, op_sel, alu_y,
    output alu_a, alu_b, alu_sel, busy, done, pass, err_count, first_fail_idx, first_fail_y
  );
endinterface

// File: rtl/alu_sweep_checker.sv
// Exhaustive checker for a 2-bit-operand ALU: walks all 16 operand pairs for one operation,
// lets each settle, compares the returned result with a reference and reports mismatches.
module alu_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_sweep_checker_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StWait, StCheck, StDone} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  state_e     r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_alu_a;
  logic [1:0] r_alu_b;
  logic [1:0] r_alu_sel;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [4:0] r_err_count;
  logic [3:0] r_ff_idx;
  logic [3:0] r_ff_y;

  logic [3:0] w_idx;
  logic [3:0] w_a4;
  logic [3:0] w_b4;
  logic [3:0] w_expected;
  logic       w_mismatch;
  logic [4:0] w_err_next;

  // The vector index is the operand pair itself, so no separate index register is kept.
  assign w_idx = {r_alu_a, r_alu_b};
  assign w_a4  = {2'b00, r_alu_a};
  assign w_b4  = {2'b00, r_alu_b};

  always_comb begin
    w_expected = 4'h0;
    unique case (r_alu_sel)
      2'b00: w_expected = w_a4 + w_b4;
      2'b01: w_expected = w_a4 - w_b4;
      2'b10: w_expected = w_a4 * w_b4;
      2'b11: w_expected = {2'b00, r_alu_a & r_alu_b};
      default: w_expected = 4'h0;
    endcase
  end

  assign w_mismatch = (bus.alu_y != w_expected);
  assign w_err_next = r_err_count + {4'b0000, w_mismatch};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= 4'h0;
      r_alu_a     <= 2'b00;
      r_alu_b     <= 2'b00;
      r_alu_sel   <= 2'b00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= 5'd0;
      r_ff_idx    <= 4'h0;
      r_ff_y      <= 4'h0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_alu_sel   <= bus.op_sel;
            r_alu_a     <= 2'b00;
            r_alu_b     <= 2'b00;
            r_err_count <= 5'd0;
            r_pass      <= 1'b0;
            r_ff_idx    <= 4'h0;
            r_ff_y      <= 4'h0;
            r_busy      <= 1'b1;
            r_cnt       <= 4'h0;
            r_state     <= StWait;
          end
        end
        StWait: begin
          if (r_cnt == SettleLast) begin
            r_state <= StCheck;
          end else begin
            r_cnt <= r_cnt + 4'h1;
          end
        end
        StCheck: begin
          r_err_count <= w_err_next;
          if (w_mismatch && (r_err_count == 5'd0)) begin
            r_ff_idx <= w_idx;
            r_ff_y   <= bus.alu_y;
          end
          // Verdict uses the updated count so a miss on the last vector is not lost.
          if (w_idx == 4'hF) begin
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 5'd0);
            r_busy  <= 1'b0;
            r_state <= StDone;
          end else begin
            {r_alu_a, r_alu_b} <= w_idx + 4'h1;
            r_cnt              <= 4'h0;
            r_state            <= StWait;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.alu_a          = r_alu_a;
  assign bus.alu_b          = r_alu_b;
  assign bus.alu_sel        = r_alu_sel;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.err_count      = r_err_count;
  assign bus.first_fail_idx = r_ff_idx;
  assign bus.first_fail_y   = r_ff_y;

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Bench for alu_sweep_checker: two instances (settle 1 with a combinational ALU, settle 3 with
// a two-cycle ALU), directed scenarios plus randomized start/op/fault traffic against a model.
module tb_alu_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  alu_sweep_checker_if u_if0 ();
  alu_sweep_checker_if u_if1 ();

  alu_sweep_checker #(.SETTLE_CYCLES(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(u_if0));
  alu_sweep_checker #(.SETTLE_CYCLES(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1));

  // ALU under test: reference arithmetic with a stuck-at fault mask applied.
  function automatic logic [3:0] alu_ref(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] sel);
    int ai;
    int bi;
    int r;
    ai = int'(a);
    bi = int'(b);
    case (sel)
      2'd0:    r = ai + bi;
      2'd1:    r = ai - bi;
      2'd2:    r = ai * bi;
      default: r = ai & bi;
    endcase
    return r[3:0];
  endfunction

  logic [3:0] and_m0 = 4'hF, or_m0 = 4'h0, and_m1 = 4'hF, or_m1 = 4'h0;
  logic [3:0] pipe1 = 4'h0, pipe2 = 4'h0;

  assign u_if0.alu_y = (alu_ref(u_if0.alu_a, u_if0.alu_b, u_if0.alu_sel) & and_m0) | or_m0;
  always @(posedge clk) begin
    pipe1 <= (alu_ref(u_if1.alu_a, u_if1.alu_b, u_if1.alu_sel) & and_m1) | or_m1;
    pipe2 <= pipe1;
  end
  assign u_if1.alu_y = pipe2;

  logic       w_busy [2];
  logic       w_done [2];
  logic       w_pass [2];
  logic [4:0] w_err  [2];
  logic [3:0] w_ffi  [2];
  logic [3:0] w_ffy  [2];
  logic [1:0] w_a    [2];
  logic [1:0] w_b    [2];
  logic [1:0] w_sel  [2];
  logic [3:0] w_y    [2];
  assign w_busy[0] = u_if0.busy;            assign w_busy[1] = u_if1.busy;
  assign w_done[0] = u_if0.done;            assign w_done[1] = u_if1.done;
  assign w_pass[0] = u_if0.pass;            assign w_pass[1] = u_if1.pass;
  assign w_err[0]  = u_if0.err_count;       assign w_err[1]  = u_if1.err_count;
  assign w_ffi[0]  = u_if0.first_fail_idx;  assign w_ffi[1]  = u_if1.first_fail_idx;
  assign w_ffy[0]  = u_if0.first_fail_y;    assign w_ffy[1]  = u_if1.first_fail_y;
  assign w_a[0]    = u_if0.alu_a;           assign w_a[1]    = u_if1.alu_a;
  assign w_b[0]    = u_if0.alu_b;           assign w_b[1]    = u_if1.alu_b;
  assign w_sel[0]  = u_if0.alu_sel;         assign w_sel[1]  = u_if1.alu_sel;
  assign w_y[0]    = u_if0.alu_y;           assign w_y[1]    = u_if1.alu_y;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: k = rising edges since the accepting edge (-1 = nothing since reset).
  int         settle [2] = '{1, 3};
  int         k      [2] = '{-1, -1};
  logic [1:0] m_op   [2];
  int         cum    [2][17];
  int         ff_vec [2];
  logic [3:0] ff_y   [2];

  task automatic model_step(input int d, input logic st, input logic [1:0] op,
                            input logic [3:0] am, input logic [3:0] om);
    int len;
    logic [3:0] g;
    logic [3:0] y;
    len = 16 * (settle[d] + 1);
    if (!rst_n) begin
      k[d] = -1;
    end else if ((k[d] < 0 || k[d] >= len + 1) && st) begin
      k[d]      = 0;
      m_op[d]   = op;
      cum[d][0] = 0;
      ff_vec[d] = -1;
      ff_y[d]   = 4'h0;
      for (int i = 0; i < 16; i++) begin
        g = alu_ref(2'(i / 4), 2'(i % 4), op);
        y = (g & am) | om;
        cum[d][i+1] = cum[d][i] + ((y != g) ? 1 : 0);
        if (y != g && ff_vec[d] < 0) begin
          ff_vec[d] = i;
          ff_y[d]   = y;
        end
      end
    end else if (k[d] >= 0) begin
      k[d]++;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, u_if0.start, u_if0.op_sel, and_m0, or_m0);
    model_step(1, u_if1.start, u_if1.op_sel, and_m1, or_m1);
  end
  always @(negedge rst_n) begin
    k[0] = -1;
    k[1] = -1;
  end

  task automatic check_outputs(input int d);
    int len, checked, idx;
    string p;
    p = (d == 0) ? "dut0" : "dut1";
    len = 16 * (settle[d] + 1);
    if (k[d] < 0) begin
      chk({p, "_busy"}, int'(w_busy[d]), 0);
      chk({p, "_done"}, int'(w_done[d]), 0);
      chk({p, "_pass"}, int'(w_pass[d]), 0);
      chk({p, "_err"},  int'(w_err[d]), 0);
      chk({p, "_ffi"},  int'(w_ffi[d]), 0);
      chk({p, "_ffy"},  int'(w_ffy[d]), 0);
      chk({p, "_a"},    int'(w_a[d]), 0);
      chk({p, "_b"},    int'(w_b[d]), 0);
      chk({p, "_sel"},  int'(w_sel[d]), 0);
    end else begin
      checked = k[d] / (settle[d] + 1);
      if (checked > 16) checked = 16;
      idx = (k[d] < len) ? k[d] / (settle[d] + 1) : 15;
      chk({p, "_busy"}, int'(w_busy[d]), (k[d] < len) ? 1 : 0);
      chk({p, "_done"}, int'(w_done[d]), (k[d] == len) ? 1 : 0);
      chk({p, "_pass"}, int'(w_pass[d]), (k[d] >= len && cum[d][16] == 0) ? 1 : 0);
      chk({p, "_err"},  int'(w_err[d]), cum[d][checked]);
      chk({p, "_ffi"},  int'(w_ffi[d]),
          (ff_vec[d] >= 0 && checked > ff_vec[d]) ? ff_vec[d] : 0);
      chk({p, "_ffy"},  int'(w_ffy[d]),
          (ff_vec[d] >= 0 && checked > ff_vec[d]) ? int'(ff_y[d]) : 0);
      chk({p, "_a"},    int'(w_a[d]), idx / 4);
      chk({p, "_b"},    int'(w_b[d]), idx % 4);
      chk({p, "_sel"},  int'(w_sel[d]), int'(m_op[d]));
    end
  endtask

  always @(negedge clk) begin
    check_outputs(0);
    check_outputs(1);
  end

  task automatic set_start(input int d, input logic v);
    if (d == 0) u_if0.start = v;
    else        u_if1.start = v;
  endtask

  // One sweep from idle: returns first done edge, done pulse count and ALU result at probe vector.
  task automatic run_sweep(input int d, input logic [1:0] op, input int restart_at,
                           input logic [3:0] probe, output int done_edge, output int n_done,
                           output logic [3:0] probe_y);
    int lim;
    lim = 16 * (settle[d] + 1) + 12;
    done_edge = -1;
    n_done    = 0;
    probe_y   = 4'h0;
    @(negedge clk);
    if (d == 0) u_if0.op_sel = op;
    else        u_if1.op_sel = op;
    set_start(d, 1'b1);
    @(posedge clk);
    #1 set_start(d, 1'b0);
    for (int n = 1; n <= lim; n++) begin
      if (n == restart_at) set_start(d, 1'b1);
      @(posedge clk);
      #1;
      set_start(d, 1'b0);
      if (w_busy[d] && {w_a[d], w_b[d]} == probe) probe_y = w_y[d];
      if (w_done[d]) begin
        n_done++;
        if (done_edge < 0) done_edge = n;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int de, nd, busy_cycles;
    logic [3:0] py;
    u_if0.start = 1'b0; u_if0.op_sel = 2'b00;
    u_if1.start = 1'b0; u_if1.op_sel = 2'b00;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(u_if0.busy), 0);
    chk("reset_err", int'(u_if0.err_count), 0);

    // Clean ALU, add: done 32 edges after acceptance, clean pass.
    run_sweep(0, 2'b00, -1, 4'h0, de, nd, py);
    chk("add_done_edge", de, 32);
    chk("add_done_pulses", nd, 1);
    chk("add_pass", int'(u_if0.pass), 1);
    chk("add_err", int'(u_if0.err_count), 0);

    // Result bit 0 stuck low: odd sums fail, first at vector 1.
    and_m0 = 4'hE;
    run_sweep(0, 2'b00, -1, 4'h0, de, nd, py);
    chk("stuck_err", int'(u_if0.err_count), 8);
    chk("stuck_ffi", int'(u_if0.first_fail_idx), 1);
    chk("stuck_ffy", int'(u_if0.first_fail_y), 0);
    chk("stuck_pass", int'(u_if0.pass), 0);
    and_m0 = 4'hF;

    run_sweep(0, 2'b01, -1, 4'h1, de, nd, py);
    chk("sub_vec1_y", int'(py), 15);
    chk("sub_pass", int'(u_if0.pass), 1);
    run_sweep(0, 2'b10, -1, 4'hF, de, nd, py);
    chk("mul_vec15_y", int'(py), 9);
    chk("mul_pass", int'(u_if0.pass), 1);

    // Start re-pulsed at edge 10 of a running sweep is ignored.
    run_sweep(0, 2'b11, 10, 4'h0, de, nd, py);
    chk("restart_done_edge", de, 32);
    chk("restart_done_pulses", nd, 1);

    // Asynchronous reset between edges 9 and 10.
    @(negedge clk);
    u_if0.op_sel = 2'b00;
    u_if0.start  = 1'b1;
    @(posedge clk);
    #1 u_if0.start = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(u_if0.busy), 0);
    chk("rst_a", int'(u_if0.alu_a), 0);
    chk("rst_b", int'(u_if0.alu_b), 0);
    chk("rst_err", int'(u_if0.err_count), 0);
    #3 rst_n = 1'b1;
    busy_cycles = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1 if (u_if0.busy) busy_cycles++;
    end
    chk("rst_idle_after_release", busy_cycles, 0);

    // Three settle cycles hide a two-cycle ALU latency.
    run_sweep(1, 2'b10, -1, 4'h0, de, nd, py);
    chk("slow_done_edge", de, 64);
    chk("slow_pass", int'(u_if1.pass), 1);

    // Random traffic: random op every cycle, sparse/held starts, random single-bit faults.
    for (int it = 0; it < 8; it++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic [3:0] am, om;
        int bit_n;
        am = 4'hF;
        om = 4'h0;
        bit_n = int'($urandom_range(3, 0));
        case ($urandom_range(2, 0))
          0: ;
          1: am[bit_n] = 1'b0;
          default: om[bit_n] = 1'b1;
        endcase
        if (d == 0) begin and_m0 = am; or_m0 = om; end
        else        begin and_m1 = am; or_m1 = om; end
      end
      for (int c = 0; c < 80; c++) begin
        u_if0.op_sel = 2'($urandom_range(3, 0));
        u_if1.op_sel = 2'($urandom_range(3, 0));
        u_if0.start  = ($urandom_range(5, 0) == 0);
        u_if1.start  = ($urandom_range(5, 0) == 0);
        @(negedge clk);
      end
      u_if0.start = 1'b0;
      u_if1.start = 1'b0;
      repeat (70) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
